// File: rtl/alu_mc.sv
// Handshaked Hack ALU with an optional multi-cycle shift-add multiplier.
// Results and flags are registered and held until the consumer accepts them.
module alu_mc #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             zr_reg, zr_next;
    logic             ng_reg, ng_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             no_reg, no_next;

    logic [WIDTH-1:0] x_z, x_p, y_z, y_p;
    logic [WIDTH-1:0] hack_r, hack_out;
    logic [WIDTH-1:0] partial, acc_sum, mul_out;
    logic             accept, mul_req;

    // Operand preprocessing on the live bundle; only used at the accept edge.
    assign x_z      = zx ? '0 : x;
    assign x_p      = nx ? ~x_z : x_z;
    assign y_z      = zy ? '0 : y;
    assign y_p      = ny ? ~y_z : y_z;
    assign hack_r   = f ? (x_p + y_p) : (x_p & y_p);
    assign hack_out = no ? ~hack_r : hack_r;

    // One shift-add step per MUL cycle; carries beyond WIDTH are dropped.
    assign partial  = mplier_reg[cnt_reg] ? (mcand_reg << cnt_reg) : '0;
    assign acc_sum  = acc_reg + partial;
    assign mul_out  = no_reg ? ~acc_sum : acc_sum;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_req   = MUL_EN && mul;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == MUL);
    assign out       = out_reg;
    assign zr        = zr_reg;
    assign ng        = ng_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            out_reg    <= '0;
            zr_reg     <= 1'b0;
            ng_reg     <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            no_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            out_reg    <= out_next;
            zr_reg     <= zr_next;
            ng_reg     <= ng_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            no_reg     <= no_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        out_next    = out_reg;
        zr_next     = zr_reg;
        ng_next     = ng_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        no_next     = no_reg;

        case (state_reg)
            MUL: begin
                acc_next = acc_sum;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST_CNT) begin
                    out_next   = mul_out;
                    zr_next    = (mul_out == '0);
                    ng_next    = mul_out[WIDTH-1];
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = state_reg;
            end
        endcase

        // Accept is only possible in IDLE or a draining DONE, so a new
        // bundle overrides the DONE->IDLE return with no bubble.
        if (accept) begin
            if (mul_req) begin
                mcand_next  = x_p;
                mplier_next = y_p;
                acc_next    = '0;
                cnt_next    = '0;
                no_next     = no;
                state_next  = MUL;
            end else begin
                out_next   = hack_out;
                zr_next    = (hack_out == '0);
                ng_next    = hack_out[WIDTH-1];
                state_next = DONE;
            end
        end
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, handshaked successor to the combinational Hack ALU. It keeps the six-bit zx/nx/zy/ny/f/no control semantics and adds a multi-cycle shift-add multiply mode. Inputs arrive over a valid/ready handshake; results and flags are registered and held until the consumer accepts them. It sits between the CPU decode/register-read stage and writeback, and allows a stallable datapath with arbitrary WIDTH.

Parameters:
WIDTH, 16, datapath width in bits (min 4)
MUL_EN, 1, 1 = multiply mode available; 0 = mul input ignored, multiply logic removed

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand/control bundle valid
in_ready  out  1  block can accept a bundle this cycle
x  in  WIDTH  operand x
y  in  WIDTH  operand y
zx  in  1  zero x
nx  in  1  invert x (after zx)
zy  in  1  zero y
ny  in  1  invert y (after zy)
f  in  1  1: x'+y', 0: x'&y' (ignored when mul=1)
no  in  1  invert result
mul  in  1  1: multiply x'*y' (low WIDTH bits)
out_valid  out  1  out/zr/ng valid
out_ready  in  1  consumer accepts result
out  out  WIDTH  result
zr  out  1  out == 0
ng  out  1  out[WIDTH-1]
busy  out  1  high while in MUL state

Behaviour:
- Reset: state=IDLE, out=0, zr=0, ng=0, out_valid=0, busy=0, in_ready=1 on the cycle after the reset edge. Reset during MUL or DONE aborts the operation. The partial result is discarded and out_valid is never raised for it.
- Operand preprocessing, combinational on the accepted bundle:
  - x' = nx ? ~(zx?0:x) : (zx?0:x)
  - y' is formed the same way from zy/ny.
- Handshake: accept when in_valid && in_ready. Operands and controls are captured at the accept edge; later changes on the inputs are ignored. in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM: IDLE, MUL, DONE.
- IDLE, accept with mul=0 (or MUL_EN=0):
  - r = f ? x'+y' : x'&y', with the sum truncated to WIDTH (carry dropped).
  - At the accept edge: out = no ? ~r : r, zr/ng are set from that out, and the FSM goes to DONE.
  - Latency is 1 cycle: out_valid is high in the cycle after accept.
- IDLE, accept with mul=1 and MUL_EN=1:
  - Latch mcand=x', mplier=y', acc=0, cnt=0, no; go to MUL.
- MUL: on each edge, if mplier[cnt] then acc += mcand<<cnt (mod 2^WIDTH); then cnt++.
  - The edge where cnt==WIDTH-1 writes out = no ? ~acc_final : acc_final, sets zr/ng, and goes to DONE.
  - That is exactly WIDTH MUL cycles; out_valid rises after edge WIDTH counted from accept.
  - busy=1 throughout MUL.
- DONE: out_valid=1. out, zr and ng are stable while out_ready=0.
  - out_ready=1 and no accept: return to IDLE, out_valid falls next cycle.
  - out_ready=1 with a simultaneous accept: the new bundle is processed as from IDLE in the same edge, with no bubble. A Hack op keeps out_valid=1 with the new result; a multiply drops out_valid and enters MUL.
- Flags are registered together with out, never computed combinationally from the live inputs.
- Overflow is silent wrap mod 2^WIDTH for both add and multiply.
- in_valid deasserted in IDLE: no state change.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges, then release -> in_ready=1, out_valid=0, out=0, zr=0, ng=0, busy=0.
2. WIDTH=16, x=0x0011, y=0x0003, ctrl zx..no=000010, mul=0, out_ready=1 -> out_valid one cycle after accept; out=0x0014, zr=0, ng=0. Then ctrl=010011 (x-y) -> 0x000E. Then ctrl=000111 (y-x) -> 0xFFF2, ng=1.
3. Backpressure: ctrl=101010 (constant 0) with out_ready=0 for 5 cycles -> out=0x0000, zr=1, ng=0, all stable; in_ready=0 throughout; releasing out_ready gives exactly one transfer.
4. Multiply: x=0x0011, y=0x0003, ctrl=000000, mul=1 -> busy for 16 cycles, out=0x0033 after edge 16. Same operands with no=1 -> 0xFFCC, ng=1. x=0x0100, y=0x0100 -> out=0x0000, zr=1.
5. Back-to-back: a stream of 4 Hack ops with in_valid=out_ready=1 -> one result per cycle with no bubbles. A multiply accepted in the DONE cycle -> out_valid drops and results are in order.
6. Reset at cycle 8 of a multiply -> IDLE next cycle, no out_valid for the aborted op; the following x+y=0x0014 is correct. WIDTH=8 instance: 0xFF+0x01 -> 0x00, zr=1.
